parallel2serial_tx: RTL and testbench
=====================================

Name: parallel2serial_tx

Overview:
- Upstream feeder for the byte deserializer stage. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock.
- Output is a serial data bit plus a qualifying valid strobe, held high for exactly WIDTH consecutive cycles per word.
- Each word is followed by a programmable idle gap, so the downstream counter-based deserializer re-aligns on every word.
- A one-word holding register lets upstream present the next word while the current one is shifting.

Parameters:
- WIDTH, 8, word width in bits (2..32).
- GAP_CYCLES, 1, number of cycles dout_valid is forced low after each word (0..15; 0 = back-to-back words).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted first; 0 = bit 0 first.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- din_parallel  input  WIDTH  word to serialize.
- din_valid  input  1  din_parallel is valid.
- din_ready  output  1  block can accept a word this cycle.
- dout_serial  output  1  serial data bit.
- dout_valid  output  1  dout_serial is valid.
- busy  output  1  a word is held, shifting, or in its gap.

Behaviour:
- Reset: one clock, asynchronous active-high reset.
  - While rst=1, all outputs are 0: din_ready, dout_serial, dout_valid, busy. Holding register is empty, shift counter is 0, state is IDLE.
  - Reset asserted mid-word aborts immediately. Partial word and held word are discarded; dout_valid drops without waiting for a clock edge.
- All outputs are registered.
- Handshake:
  - A word is accepted on a rising edge where din_valid=1 and din_ready=1; it is written into the holding register.
  - din_ready = 1 exactly when the holding register is empty. It rises on the first edge after reset release.
  - din_ready falls on the edge that fills the holding register and rises on the edge that moves the held word into the shifter.
  - While din_ready=0, din_valid and din_parallel are ignored; upstream must hold them.
  - A word is never accepted on the same edge it is transferred.
- State machine (IDLE, SHIFT, GAP):
  - IDLE: if the holding register is full, load the shifter, drive the first bit, set dout_valid=1, set bit counter=1, go to SHIFT.
  - SHIFT: each edge drives the next bit. After the edge that drives bit number WIDTH, the next edge:
    - goes to GAP with dout_valid=0 when GAP_CYCLES>0;
    - when GAP_CYCLES=0, loads the held word directly and stays in SHIFT, or goes to IDLE if no word is held.
  - GAP: dout_valid=0 and dout_serial=0 for exactly GAP_CYCLES cycles. On the last gap edge, a held word is loaded into SHIFT (dout_valid=1); otherwise go to IDLE.
- Latency and throughput:
  - Word accepted at edge E0 → first bit visible after edge E1. Bits occupy WIDTH consecutive cycles.
  - Sustained throughput is one word per WIDTH+GAP_CYCLES cycles. The holding register refills during the shift, so no extra bubbles occur.
- Data rules:
  - Bit order follows MSB_FIRST.
  - dout_serial is 0 whenever dout_valid=0.
  - Word data is captured in full at acceptance; later changes on din_parallel do not affect it.
- busy = (state != IDLE) or holding register full. busy is 0 only when fully drained.
- Bit counter is clog2(WIDTH+1) bits wide; gap counter is 4 bits wide. Neither wraps beyond its terminal value.

Test Plan:
- Single word, WIDTH=8, GAP=1, MSB_FIRST=1:
  - Stimulus: 0xA5 accepted at E0.
  - Required: dout_valid high for cycles E1..E8 with bits 1,0,1,0,0,1,0,1, then low for 1 cycle; busy returns 0 after the gap.
- Back-to-back:
  - Stimulus: din_valid held with 0x3C then 0xC3.
  - Required: din_ready low for E0..E1 and E2..E10 windows as specified. Serial output is 00111100, one gap cycle, 11000011, with dout_valid pattern 8 high / 1 low / 8 high.
- Loopback with downstream deserializer:
  - Stimulus: 16 random bytes, GAP=1.
  - Required: deserializer emits the same 16 bytes in order, each with a one-cycle dout_valid pulse.
- Backpressure:
  - Stimulus: while shifting with the holding register full, upstream changes din_parallel every cycle with din_valid=1.
  - Required: no extra words are accepted, and only the held value is transmitted next.
- Reset mid-word:
  - Stimulus: assert rst asynchronously after bit 3 of 0xFF, with a second word held.
  - Required: dout_valid=0 immediately. After release, din_ready=1 and no remnant bits are output.
- Parameter variants:
  - GAP_CYCLES=0, MSB_FIRST=0, WIDTH=8 with words 0x01, 0x80: output 10000000 00000001 with dout_valid high for 16 contiguous cycles.

Source files
------------

// File: rtl/parallel2serial_tx.sv
// Parallel-to-serial transmitter: valid/ready word input, one bit per clock out,
// with a programmable idle gap after each word and a one-word holding register.
`timescale 1ns/1ps
module parallel2serial_tx #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_parallel,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout_serial,
    output logic             dout_valid,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [3:0]       gap_cnt, gap_cnt_n;
    logic             hold_full, hold_full_n;
    logic [WIDTH-1:0] hold_data;
    logic [WIDTH-1:0] shift_reg;
    logic             load, advance, accept;
    logic             dout_serial_n, dout_valid_n, din_ready_n, busy_n;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        gap_cnt_n     = gap_cnt;
        hold_full_n   = hold_full;
        load          = 1'b0;
        advance       = 1'b0;
        dout_valid_n  = 1'b0;
        dout_serial_n = 1'b0;
        accept        = din_valid && din_ready;

        case (state)
            IDLE: begin
                if (hold_full) load = 1'b1;
            end
            SHIFT: begin
                if (bit_cnt != CNT_LAST) begin
                    advance = 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    state_n   = GAP;
                    gap_cnt_n = 4'd1;
                end else if (hold_full) begin
                    load = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (hold_full) load = 1'b1;
                    else           state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Transfer and acceptance are mutually exclusive: acceptance needs an empty holder.
        if (load) begin
            state_n       = SHIFT;
            bit_cnt_n     = CNT_W'(1);
            gap_cnt_n     = '0;
            hold_full_n   = 1'b0;
            dout_valid_n  = 1'b1;
            dout_serial_n = first_bit(hold_data);
        end
        if (advance) begin
            bit_cnt_n     = bit_cnt + CNT_W'(1);
            dout_valid_n  = 1'b1;
            dout_serial_n = first_bit(shift_reg);
        end
        if (accept) hold_full_n = 1'b1;

        din_ready_n = !hold_full_n;
        busy_n      = (state_n != IDLE) || hold_full_n;
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            hold_full   <= 1'b0;
            din_ready   <= 1'b0;
            dout_valid  <= 1'b0;
            dout_serial <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            gap_cnt     <= gap_cnt_n;
            hold_full   <= hold_full_n;
            din_ready   <= din_ready_n;
            dout_valid  <= dout_valid_n;
            dout_serial <= dout_serial_n;
            busy        <= busy_n;
        end
    end

    // Data path registers
    always_ff @(posedge clk) begin
        if (accept) hold_data <= din_parallel;
        if (load)         shift_reg <= drop_bit(hold_data);
        else if (advance) shift_reg <= drop_bit(shift_reg);
    end

endmodule

// File: tb/tb_parallel2serial_tx.sv
// Bench for parallel2serial_tx: instance A (8b, gap 1, MSB first) and
// instance B (8b, gap 0, LSB first), scoreboard-checked against a word/bit model.
`timescale 1ns/1ps
module tb_parallel2serial_tx;
    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic [7:0] din_a = '0, din_b = '0;
    logic       vin_a = 1'b0, vin_b = 1'b0;
    logic       rdy_a, rdy_b, ser_a, ser_b, vout_a, vout_b, busy_a, busy_b;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_a[$];
    logic       exp_b[$];
    int         rx_a = 0;

    always #5 clk = ~clk;

    parallel2serial_tx #(.WIDTH(8), .GAP_CYCLES(1), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .din_parallel(din_a), .din_valid(vin_a),
        .din_ready(rdy_a), .dout_serial(ser_a), .dout_valid(vout_a), .busy(busy_a));

    parallel2serial_tx #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .din_parallel(din_b), .din_valid(vin_b),
        .din_ready(rdy_b), .dout_serial(ser_b), .dout_valid(vout_b), .busy(busy_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Offer a word; junk is driven while the DUT is not ready. Returns 1ns after the accepting edge.
    task automatic send(input bit sel_b, input logic [7:0] w);
        int n = 0;
        @(negedge clk);
        if (sel_b) vin_b = 1'b1; else vin_a = 1'b1;
        while (!(sel_b ? rdy_b : rdy_a) && n < 200) begin
            if (sel_b) din_b = 8'($urandom); else din_a = 8'($urandom);
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 200), 32'd1);
        if (sel_b) begin
            din_b = w;
            for (int i = 0; i < 8; i++) exp_b.push_back(w[i]);
        end else begin
            din_a = w;
            exp_a.push_back(w);
        end
        @(posedge clk);
        #1;
        if (sel_b) vin_b = 1'b0; else vin_a = 1'b0;
    endtask

    task automatic drain(input bit sel_b);
        int n = 0;
        while ((sel_b ? busy_b : busy_a) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(sel_b ? "drain_b" : "drain_a", 32'(sel_b ? busy_b : busy_a), 32'd0);
    endtask

    // Monitor A: counter-based deserializer model, MSB-first assembly, word-level scoreboard
    logic [7:0] acc_a = '0;
    int nb_a = 0, run_a = 0;
    always @(negedge clk) begin
        if (rst_a) begin
            nb_a = 0; run_a = 0;
        end else if (vout_a) begin
            acc_a = {acc_a[6:0], ser_a};
            nb_a++; run_a++;
            if (nb_a == 8) begin
                nb_a = 0;
                rx_a++;
                if (exp_a.size() == 0) check("unexpected_word_a", 32'(acc_a), 32'hxx);
                else check("word_a", 32'(acc_a), 32'(exp_a.pop_front()));
            end
        end else begin
            check("idle_serial_a", 32'(ser_a), 32'd0);
            if (run_a != 0) begin
                check("run_len_a", 32'(run_a), 32'd8);
                run_a = 0;
            end
        end
    end

    // Monitor B: bit-level scoreboard
    int run_b = 0;
    always @(negedge clk) begin
        if (rst_b) begin
            run_b = 0;
        end else if (vout_b) begin
            run_b++;
            if (exp_b.size() == 0) check("unexpected_bit_b", 32'(ser_b), 32'hx);
            else check("bit_b", 32'(ser_b), 32'(exp_b.pop_front()));
        end else begin
            check("idle_serial_b", 32'(ser_b), 32'd0);
            if (run_b != 0) begin
                check("run_mod_b", 32'(run_b % 8), 32'd0);
                run_b = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        // Reset state
        #12;
        check("rst_ready_a", 32'(rdy_a), 32'd0);
        check("rst_valid_a", 32'(vout_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_serial_a", 32'(ser_a), 32'd0);
        check("rst_ready_b", 32'(rdy_b), 32'd0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;
        check("ready_after_release_a", 32'(rdy_a), 32'd1);
        check("ready_after_release_b", 32'(rdy_b), 32'd1);

        // Single word 0xA5
        send(1'b0, 8'hA5);
        check("single_ready_e0", 32'(rdy_a), 32'd0);
        check("single_busy_e0", 32'(busy_a), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            check("single_valid", 32'(vout_a), 32'(k <= 8));
            if (k == 1) check("single_ready_e1", 32'(rdy_a), 32'd1);
            check("single_busy", 32'(busy_a), 32'(k <= 9));
        end

        // Back-to-back 0x3C then 0xC3
        send(1'b0, 8'h3C);
        check("b2b_ready_e0", 32'(rdy_a), 32'd0);
        send(1'b0, 8'hC3);
        check("b2b_ready_e2", 32'(rdy_a), 32'd0);
        for (int k = 3; k <= 18; k++) begin
            @(posedge clk); #1;
            check("b2b_valid", 32'(vout_a), 32'((k <= 8) || (k >= 10 && k <= 17)));
            check("b2b_ready", 32'(rdy_a), 32'(k >= 10));
        end
        drain(1'b0);

        // Loopback: 16 random bytes, back-to-back
        rx_a = 0;
        for (int i = 0; i < 16; i++) send(1'b0, 8'($urandom));
        drain(1'b0);
        check("loopback_count", 32'(rx_a), 32'd16);

        // Backpressure: third word offered with junk while holder full
        send(1'b0, 8'h5A);
        send(1'b0, 8'h96);
        send(1'b0, 8'($urandom));
        drain(1'b0);
        check("bp_pending", 32'(exp_a.size()), 32'd0);

        // Reset mid-word after bit 3 of 0xFF, with a second word held
        send(1'b0, 8'hFF);
        send(1'b0, 8'h81);
        @(posedge clk);
        #2 rst_a = 1'b1;
        #1;
        check("midrst_valid", 32'(vout_a), 32'd0);
        check("midrst_serial", 32'(ser_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_ready", 32'(rdy_a), 32'd0);
        exp_a.delete();
        @(negedge clk); @(negedge clk);
        rst_a = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready_release", 32'(rdy_a), 32'd1);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check("midrst_no_remnant", 32'(vout_a), 32'd0);
        end

        // Random traffic on A with random idle spacing
        for (int i = 0; i < 30; i++) begin
            send(1'b0, 8'($urandom));
            repeat ($urandom_range(0, 12)) @(posedge clk);
        end
        drain(1'b0);

        // Instance B: 0x01 then 0x80, LSB first, no gap
        send(1'b1, 8'h01);
        send(1'b1, 8'h80);
        for (int k = 3; k <= 18; k++) begin
            @(posedge clk); #1;
            check("b_contig_valid", 32'(vout_b), 32'(k <= 16));
        end
        drain(1'b1);
        for (int i = 0; i < 20; i++) begin
            w = 8'($urandom);
            send(1'b1, w);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 10)) @(posedge clk);
        end
        drain(1'b1);

        repeat (3) @(posedge clk);
        check("final_pending_a", 32'(exp_a.size()), 32'd0);
        check("final_pending_b", 32'(exp_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
